pic_ctrl: RTL
=============

# pic_ctrl

Parametrised, memory-mapped programmable interrupt controller replacing the fixed 8-input combinational priority encoder in the top-level glue. It sits between the peripheral IRQ lines (switchbanks, timers, ...) and the CPU's `INT`/`intack` pins. It adds:
- per-line mask, edge/level mode and pending latching;
- in-service tracking with nested priority and end-of-interrupt (EOI) commands;
- a vector latched at acknowledge, driven onto the CPU data-in mux.

## Interface
Parameters:
- `NUM_IRQ`, 8, number of IRQ lines, legal range 1..15; index 0 has the highest priority.
- `ADDR_W`, 12, CPU address width.
- `DATA_W`, 16, CPU data width; must be at least `NUM_IRQ`.
- `BASE_ADDR`, 12'hc00, base of the 8-word register window.

Ports:
- `clk` in 1: system clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high reset.
- `irq` in `NUM_IRQ`: device request lines, synchronous to `clk`.
- `address` in `ADDR_W`: CPU address bus.
- `wdata` in `DATA_W`: CPU `data_out`.
- `memwt` in 1: CPU write strobe.
- `intack` in 1: CPU interrupt acknowledge.
- `INT` out 1: interrupt request to the CPU.
- `sel` out 1: high when `address` is in `BASE_ADDR..BASE_ADDR+7`. The top-level mux uses it to select `rdata`.
- `rdata` out `DATA_W`: register read data, or the vector while `intack` is high.

## Operation
Registers, at `BASE_ADDR` + offset. All are `NUM_IRQ` bits, zero-extended on read.
- 0 MASK, R/W, reset 0. Bit=1 masks the line.
- 1 PENDING, R/W1C, reset 0.
- 2 MODE, R/W, reset 0. Bit=0 is level mode, bit=1 is rising-edge mode.
- 3 INSERVICE, R only, reset 0.
- 4 EOI, W only.
  - `wdata[15]`=0: nonspecific; clears the highest-priority set INSERVICE bit.
  - `wdata[15]`=1: specific; clears bit `wdata[3:0]`, ignored if the index is `>= NUM_IRQ`.
  - Reads return 0.
- 5 VECTOR, R only: last latched vector, reset 0.
- 6–7: reserved. Reads return 0; writes are ignored.

Pending logic:
- `irq_q` is a registered copy of `irq`.
- Level line: `PENDING[i] <= irq[i]` every cycle. W1C has no lasting effect.
- Edge line: `PENDING[i]` is set on `irq[i] & ~irq_q[i]`. It is cleared by W1C or by acknowledge of line i.
- A set and a clear in the same cycle: set wins.

Request and priority:
- `req = PENDING & ~MASK`.
- `best` = lowest index set in `req`.
- `top_is` = lowest index set in INSERVICE, or `NUM_IRQ` if INSERVICE is empty.
- `INT = |req && best < top_is` (nesting: only a strictly higher priority preempts).

Acknowledge FSM, states IDLE and ACK:
- IDLE → ACK on the first cycle `intack`=1. In that cycle:
  - if `INT` is valid: latch `VECTOR <= best`, set `INSERVICE[best]`, clear `PENDING[best]` if edge-mode;
  - otherwise (spurious): latch `VECTOR <= NUM_IRQ` and leave INSERVICE/PENDING untouched.
- ACK: `rdata = VECTOR` and `INT` is forced to 0. Stay in ACK while `intack`=1; go to IDLE when `intack`=0.
- `intack`=1 overrides `sel` for `rdata`.

Other rules:
- Writes are ignored while `intack`=1.
- Changing MODE from edge to level takes effect next cycle; PENDING is then overwritten by the level sample.

## Timing
- `reset`: all registers and `irq_q` go to 0, FSM to IDLE. `INT`=0 and `rdata`=0 (no `sel`) in the cycle after reset is sampled.
- Reset mid-acknowledge returns to IDLE and drops INSERVICE.
- Latency, `irq` edge or level to `INT`: 1 cycle, via the PENDING register; `INT` is combinational from registers.
- `rdata` register reads are combinational from `address` with zero wait states. The vector is valid in the same cycle `intack` rises; `VECTOR` is updated at the end of that cycle.
- MASK/MODE/PENDING writes take effect on the next cycle's `INT`.
- EOI re-enables `INT` for equal or lower lines in the cycle after the write.

## Test plan
- **Reset and level request**
  - Stimulus: reset, then `irq[2]`=1 held.
  - `INT`=1 one cycle later.
  - Pulse `intack`: `rdata`=16'h0002, INSERVICE=0x04, `INT`=0.
  - Drop `irq[2]` and write EOI 0: INSERVICE=0, `INT`=0.
- **Priority and nesting**
  - Start with `irq[5]` in service; raise `irq[1]`: `INT`=1, ack vector 1, INSERVICE=0x22.
  - Raise `irq[6]` while 1 and 5 are in service: `INT` stays 0 until both EOIs are written.
- **Edge mode**
  - Set MODE=0x08 and pulse `irq[3]` for 1 cycle: PENDING=0x08 persists.
  - Ack clears it.
  - New edge in the same cycle as a W1C write of 0x08: PENDING stays 0x08.
- **Masking**
  - MASK=0x04 with `irq[2]`=1: `INT`=0 and PENDING=0x04.
  - Write MASK=0: `INT`=1 the next cycle.
- **Spurious acknowledge**
  - `intack` with no request: `rdata`=`NUM_IRQ` (16'h0008 for the default); INSERVICE unchanged.
  - Repeat with `NUM_IRQ`=12, checking vectors up to 11 and spurious code 12.
- **Reset mid-acknowledge**
  - Assert `reset` while `intack`=1 in ACK: next cycle FSM is IDLE and all registers are 0.
  - Deassert `intack`, then raise `irq[0]`: a normal cycle yields vector 0.

Source files
------------

// File: rtl/pic_ctrl.sv
// pic_ctrl: memory-mapped programmable interrupt controller.
// Collects NUM_IRQ device request lines and applies per-line mask and
// edge/level mode. It tracks in-service lines for nested priority and EOI,
// and latches the interrupt vector when the CPU acknowledges.
// Register window (BASE_ADDR + offset):
//   0 MASK (R/W)   1 PENDING (R/W1C)   2 MODE (R/W, 1 = rising edge)
//   3 INSERVICE (R)   4 EOI (W)   5 VECTOR (R)   6-7 reserved
module pic_ctrl #(
   parameter int                NUM_IRQ   = 8,
   parameter int                ADDR_W    = 12,
   parameter int                DATA_W    = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 12'hc00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq,
   input  logic [ADDR_W-1:0]  address,
   input  logic [DATA_W-1:0]  wdata,
   input  logic               memwt,
   input  logic               intack,
   output logic               INT,
   output logic               sel,
   output logic [DATA_W-1:0]  rdata
);

   // A vector holds a line index 0..14 or the spurious code NUM_IRQ (<= 15).
   localparam int               VEC_W    = 4;
   localparam logic [VEC_W-1:0] SPURIOUS = VEC_W'(NUM_IRQ);
   // Bit that selects a specific EOI. It is bit 15 on a full-width bus.
   localparam int               EOI_BIT  = (DATA_W > 15) ? 15 : DATA_W - 1;

   typedef enum logic {
      ST_IDLE,
      ST_ACK
   } state_t;

   state_t             state_q, state_d;
   logic [NUM_IRQ-1:0] irq_q;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] pending_q, pending_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   logic [NUM_IRQ-1:0] inservice_q, inservice_d;
   logic [VEC_W-1:0]   vector_q, vector_d;

   logic [ADDR_W-1:0]  offset;
   logic [2:0]         reg_off;
   logic [NUM_IRQ-1:0] req;
   logic [VEC_W-1:0]   best;
   logic [VEC_W-1:0]   top_is;
   logic [NUM_IRQ-1:0] best_oh;
   logic [NUM_IRQ-1:0] top_oh;
   logic [NUM_IRQ-1:0] spec_oh;
   logic [NUM_IRQ-1:0] eoi_clr;
   logic [3:0]         eoi_idx;
   logic               int_valid;
   logic               ack_take;
   logic               ack_valid;
   logic               wr_en;
   logic               wr_mask;
   logic               wr_pend;
   logic               wr_mode;
   logic               wr_eoi;
   logic               unused_bits;

   // ------------------------------------------------------------------
   // Address decode. Subtracting the base also handles an unaligned base.
   // ------------------------------------------------------------------
   assign offset  = address - BASE_ADDR;
   assign sel     = (offset < ADDR_W'(8));
   assign reg_off = offset[2:0];

   // The CPU cannot write while it is acknowledging.
   assign wr_en   = memwt && sel && !intack;
   assign wr_mask = wr_en && (reg_off == 3'd0);
   assign wr_pend = wr_en && (reg_off == 3'd1);
   assign wr_mode = wr_en && (reg_off == 3'd2);
   assign wr_eoi  = wr_en && (reg_off == 3'd4);

   assign eoi_idx = 4'(wdata);

   // Data bits above the register width are accepted but never stored.
   assign unused_bits = ^{1'b0, wdata};

   // ------------------------------------------------------------------
   // Priority resolution
   // ------------------------------------------------------------------
   assign req = pending_q & ~mask_q;

   // Lowest-index requesting line, or SPURIOUS when nothing requests.
   always_comb begin
      best = SPURIOUS;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            best = VEC_W'(i);
         end
      end
   end

   // Highest-priority line in service, or NUM_IRQ when none is active.
   always_comb begin
      top_is = SPURIOUS;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (inservice_q[i]) begin
            top_is = VEC_W'(i);
         end
      end
   end

   // Only a strictly higher priority line can preempt an active handler.
   assign int_valid = (|req) && (best < top_is);

   assign ack_take  = (state_q == ST_IDLE) && intack;
   assign ack_valid = ack_take && int_valid;

   // ------------------------------------------------------------------
   // Per-line next-state logic
   // ------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < NUM_IRQ; gi++) begin : g_line
         logic edge_set;
         logic edge_clr;

         assign best_oh[gi] = (best == VEC_W'(gi));
         assign top_oh[gi]  = (top_is == VEC_W'(gi));
         assign spec_oh[gi] = (eoi_idx == 4'(gi));

         // Edge lines latch a rising edge until it is acknowledged or
         // cleared by W1C. A new edge in the same cycle beats the clear.
         // Level lines simply follow the input.
         assign edge_set = irq[gi] & ~irq_q[gi];
         assign edge_clr = (wr_pend & wdata[gi]) | (ack_valid & best_oh[gi]);
         assign pending_d[gi] = mode_q[gi] ? (edge_set | (pending_q[gi] & ~edge_clr))
                                           : irq[gi];

         // A specific EOI with an out-of-range index matches no line.
         assign eoi_clr[gi] = wr_eoi & (wdata[EOI_BIT] ? spec_oh[gi] : top_oh[gi]);
         assign inservice_d[gi] = (inservice_q[gi] & ~eoi_clr[gi])
                                | (ack_valid & best_oh[gi]);
      end
   endgenerate

   assign mask_d   = wr_mask ? wdata[NUM_IRQ-1:0] : mask_q;
   assign mode_d   = wr_mode ? wdata[NUM_IRQ-1:0] : mode_q;
   assign vector_d = ack_take ? (int_valid ? best : SPURIOUS) : vector_q;

   // ------------------------------------------------------------------
   // Acknowledge FSM
   // ------------------------------------------------------------------
   // Next state and INT; INT is held low for the whole acknowledge.
   always_comb begin
      state_d = state_q;
      INT     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            INT = int_valid;
            if (intack) begin
               state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (!intack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Read mux. During acknowledge the vector is shown, including in the
   // first cycle, before VECTOR has been written.
   always_comb begin
      rdata = '0;
      if (intack) begin
         rdata = DATA_W'((state_q == ST_IDLE) ? vector_d : vector_q);
      end else if (sel) begin
         case (reg_off)
            3'd0:    rdata = DATA_W'(mask_q);
            3'd1:    rdata = DATA_W'(pending_q);
            3'd2:    rdata = DATA_W'(mode_q);
            3'd3:    rdata = DATA_W'(inservice_q);
            3'd5:    rdata = DATA_W'(vector_q);
            default: rdata = '0;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         irq_q       <= '0;
         mask_q      <= '0;
         pending_q   <= '0;
         mode_q      <= '0;
         inservice_q <= '0;
         vector_q    <= '0;
      end else begin
         state_q     <= state_d;
         irq_q       <= irq;
         mask_q      <= mask_d;
         pending_q   <= pending_d;
         mode_q      <= mode_d;
         inservice_q <= inservice_d;
         vector_q    <= vector_d;
      end
   end

endmodule
